// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store with fixed latency,
// byte/half/word lane handling, sign/zero extension and fault reporting.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_fault
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]    state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          accept_c, commit_c;

    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_unsigned;

    logic        op_write;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [1:0]  op_size;
    logic        op_unsigned;

    logic          fault_c;
    logic [AW-1:0] word_idx_c;
    logic [3:0]    lane_en_c;
    logic [31:0]   wr_data_c;
    logic [31:0]   rd_word_c;
    logic [7:0]    rd_byte_c;
    logic [15:0]   rd_half_c;
    logic [31:0]   load_data_c;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept_c = req_valid && req_ready;

    // Next-state and countdown; commit_c marks the edge that enters RESP
    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        commit_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept_c) begin
                    if (LATENCY <= 1) begin
                        nxt_state = S_RESP;
                        commit_c  = 1'b1;
                    end else begin
                        nxt_state = S_WAIT;
                        nxt_cnt   = CW'(LATENCY - 2);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    nxt_state = S_RESP;
                    commit_c  = 1'b1;
                end else begin
                    nxt_cnt = cnt - CW'(1);
                end
            end
            S_RESP: begin
                if (resp_valid && resp_ready) nxt_state = S_IDLE;
            end
            default: nxt_state = S_IDLE;
        endcase
    end

    // With single-cycle latency the commit edge is the accept edge, so use live inputs
    always_comb begin
        if (state == S_IDLE) begin
            op_write    = req_write;
            op_addr     = req_addr;
            op_wdata    = req_wdata;
            op_size     = req_size;
            op_unsigned = req_unsigned;
        end else begin
            op_write    = lat_write;
            op_addr     = lat_addr;
            op_wdata    = lat_wdata;
            op_size     = lat_size;
            op_unsigned = lat_unsigned;
        end
    end

    // Access decode: fault detection, lane enables and store data replication
    always_comb begin
        fault_c = (op_size == 2'b11)
               || (op_size == 2'b01 && op_addr[0])
               || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
               || (op_addr[31:2] >= 30'(DEPTH_WORDS));
        word_idx_c = op_addr[AW+1:2];
        case (op_size)
            2'b00:   lane_en_c = 4'b0001 << op_addr[1:0];
            2'b01:   lane_en_c = op_addr[1] ? 4'b1100 : 4'b0011;
            2'b10:   lane_en_c = 4'b1111;
            default: lane_en_c = 4'b0000;
        endcase
        case (op_size)
            2'b00:   wr_data_c = {4{op_wdata[7:0]}};
            2'b01:   wr_data_c = {2{op_wdata[15:0]}};
            default: wr_data_c = op_wdata;
        endcase
    end

    // Load lane extraction and extension
    always_comb begin
        rd_word_c = mem[word_idx_c];
        case (op_addr[1:0])
            2'b00:   rd_byte_c = rd_word_c[7:0];
            2'b01:   rd_byte_c = rd_word_c[15:8];
            2'b10:   rd_byte_c = rd_word_c[23:16];
            default: rd_byte_c = rd_word_c[31:24];
        endcase
        rd_half_c = op_addr[1] ? rd_word_c[31:16] : rd_word_c[15:0];
        case (op_size)
            2'b00:   load_data_c = op_unsigned ? {24'h0, rd_byte_c}
                                               : {{24{rd_byte_c[7]}}, rd_byte_c};
            2'b01:   load_data_c = op_unsigned ? {16'h0, rd_half_c}
                                               : {{16{rd_half_c[15]}}, rd_half_c};
            default: load_data_c = rd_word_c;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else begin
            state      <= nxt_state;
            cnt        <= nxt_cnt;
            req_ready  <= (nxt_state == S_IDLE);
            resp_valid <= (nxt_state == S_RESP);
            if (commit_c) begin
                resp_rdata <= (fault_c || op_write) ? '0 : load_data_c;
                resp_fault <= fault_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= '0;
            lat_unsigned <= 1'b0;
        end else if (accept_c) begin
            lat_write    <= req_write;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
        end
    end

    // Storage is not reset; reset only suppresses an in-flight commit
    always_ff @(posedge clk) begin
        if (!rst && commit_c && op_write && !fault_c) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en_c[i]) mem[word_idx_c][8*i +: 8] <= wr_data_c[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with LATENCY=1 (index 0)
// and one with LATENCY=3 (index 1), sharing a clock.
module tb_data_mem_responder;

    logic clk;
    logic [1:0]       rst;
    logic [1:0]       req_valid;
    logic [1:0]       req_write;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_unsigned;
    logic [1:0]       resp_ready;
    wire  [1:0]       req_ready;
    wire  [1:0]       resp_valid;
    wire  [1:0][31:0] resp_rdata;
    wire  [1:0]       resp_fault;

    int tests = 0;
    int fails = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0])
    );

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete transaction on instance d with resp_ready held high; lat counts
    // cycles from acceptance to the first cycle with resp_valid (-1 on timeout).
    task automatic xact(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        output logic [31:0] rdata, output logic fault, output int lat);
        int k;
        rdata = '0;
        fault = 1'b0;
        lat   = -1;
        @(negedge clk);
        req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = addr;
        req_wdata[d] = wdata; req_size[d] = size; req_unsigned[d] = uns;
        resp_ready[d] = 1'b1;
        k = 0;
        while (!req_ready[d] && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (resp_valid[d]) begin
                lat   = c;
                rdata = resp_rdata[d];
                fault = resp_fault[d];
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 2'b11; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        req_size = '0; req_unsigned = '0; resp_ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b, expected 00", req_ready); end
        tests++;
        if (resp_valid !== 2'b00) begin fails++; $display("FAIL reset_resp_valid: got %b, expected 00", resp_valid); end
        tests++;
        if (resp_rdata !== 64'h0 || resp_fault !== 2'b00) begin
            fails++; $display("FAIL reset_resp_data: got %h/%b, expected 0/00", resp_rdata, resp_fault);
        end
        rst = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (req_ready !== 2'b11) begin fails++; $display("FAIL post_reset_ready: got %b, expected 11", req_ready); end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic f; int lat;
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== 33'h0 || lat != 1) begin
            fails++; $display("FAIL word_store: got fault=%b rdata=%h lat=%0d, expected 0 0 1", f, rd, lat);
        end
        xact(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b0, 32'hDEADBEEF} || lat != 1) begin
            fails++; $display("FAIL word_load: got fault=%b rdata=%h lat=%0d, expected 0 deadbeef 1", f, rd, lat);
        end
    endtask

    task automatic test_lanes();
        logic [31:0] rd; logic f; int lat;
        xact(0, 1'b1, 32'h13, 32'hFFFFFF80, 2'b00, 1'b0, rd, f, lat);
        xact(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, rd, f, lat);
        tests++;
        if (rd !== 32'hFFFFFF80 || f !== 1'b0) begin fails++; $display("FAIL lb_signed: got %h, expected ffffff80", rd); end
        xact(0, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, rd, f, lat);
        tests++;
        if (rd !== 32'h00000080) begin fails++; $display("FAIL lb_unsigned: got %h, expected 00000080", rd); end
        xact(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b1, rd, f, lat);
        tests++;
        if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL lw_after_sb: got %h, expected 80adbeef", rd); end
        xact(0, 1'b1, 32'h12, 32'hAAAA1234, 2'b01, 1'b0, rd, f, lat);
        xact(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if (rd !== 32'h1234BEEF) begin fails++; $display("FAIL lw_after_sh: got %h, expected 1234beef", rd); end
        xact(0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b0, rd, f, lat);
        tests++;
        if (rd !== 32'hFFFFBEEF) begin fails++; $display("FAIL lh_signed: got %h, expected ffffbeef", rd); end
        xact(0, 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, rd, f, lat);
        tests++;
        if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL lh_unsigned: got %h, expected 0000beef", rd); end
        xact(0, 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, rd, f, lat);
        tests++;
        if (rd !== 32'hFFFFFFBE) begin fails++; $display("FAIL lb_lane1: got %h, expected ffffffbe", rd); end
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic f; int lat;
        xact(0, 1'b0, 32'h11, 32'h0, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b1, 32'h0}) begin fails++; $display("FAIL fault_lw_misaligned: got %b/%h, expected 1/0", f, rd); end
        xact(0, 1'b1, 32'h13, 32'h0000FFFF, 2'b01, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b1, 32'h0}) begin fails++; $display("FAIL fault_sh_misaligned: got %b/%h, expected 1/0", f, rd); end
        xact(0, 1'b1, 32'h10, 32'hFFFFFFFF, 2'b11, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b1, 32'h0}) begin fails++; $display("FAIL fault_size11: got %b/%h, expected 1/0", f, rd); end
        xact(0, 1'b1, 32'h1000, 32'h5A5A5A5A, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b1, 32'h0}) begin fails++; $display("FAIL fault_range: got %b/%h, expected 1/0", f, rd); end
        xact(0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b0, 32'h1234BEEF}) begin fails++; $display("FAIL fault_no_effect: got %b/%h, expected 0/1234beef", f, rd); end
        xact(0, 1'b1, 32'hFFC, 32'hCAFEF00D, 2'b10, 1'b0, rd, f, lat);
        xact(0, 1'b0, 32'hFFC, 32'h0, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if ({f, rd} !== {1'b0, 32'hCAFEF00D}) begin fails++; $display("FAIL top_word: got %b/%h, expected 0/cafef00d", f, rd); end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic f; int lat; int k; int bad;
        xact(1, 1'b1, 32'h20, 32'h11223344, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if (lat != 3 || f !== 1'b0) begin fails++; $display("FAIL l3_store_latency: got %0d, expected 3", lat); end
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h20; req_size[1] = 2'b10;
        resp_ready[1] = 1'b0;
        tests++;
        if (req_ready[1] !== 1'b1) begin fails++; $display("FAIL l3_idle_ready: got %b, expected 1", req_ready[1]); end
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        k = -1; bad = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (req_ready[1] !== 1'b0) bad++;
            if (resp_valid[1]) begin k = c; break; end
        end
        tests++;
        if (k != 3 || bad != 0) begin fails++; $display("FAIL l3_latency: got %0d (ready errs %0d), expected 3 (0)", k, bad); end
        tests++;
        if (resp_rdata[1] !== 32'h11223344) begin fails++; $display("FAIL l3_rdata: got %h, expected 11223344", resp_rdata[1]); end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (resp_valid[1] !== 1'b1 || req_ready[1] !== 1'b0 || resp_rdata[1] !== 32'h11223344) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL l3_backpressure: got %0d unstable cycles, expected 0", bad); end
        resp_ready[1] = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (req_ready[1] !== 1'b1 || resp_valid[1] !== 1'b0) begin
            fails++; $display("FAIL l3_after_handshake: got ready=%b valid=%b, expected 1 0", req_ready[1], resp_valid[1]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic f; int lat; int bad;
        @(negedge clk);
        req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 32'h20;
        req_wdata[1] = 32'h55; req_size[1] = 2'b00; resp_ready[1] = 1'b1;
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (resp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
            fails++; $display("FAIL midrst_outputs: got valid=%b ready=%b, expected 0 0", resp_valid[1], req_ready[1]);
        end
        @(negedge clk);
        rst[1] = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (resp_valid[1] !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || req_ready[1] !== 1'b1) begin
            fails++; $display("FAIL midrst_idle: got %0d valid cycles ready=%b, expected 0 1", bad, req_ready[1]);
        end
        xact(1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, f, lat);
        tests++;
        if (rd !== 32'h11223344) begin fails++; $display("FAIL midrst_readback: got %h, expected 11223344", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic f; int lat;
        logic [31:0] got [4];
        int at [4];
        int i; int n; logic acc;
        for (int j = 0; j < 4; j++) begin
            xact(1, 1'b1, 32'h30 + 32'(4*j), 32'h0BAD0000 + 32'(j), 2'b10, 1'b0, rd, f, lat);
            got[j] = '0; at[j] = 0;
        end
        i = 0; n = 0;
        resp_ready[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b10;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (resp_valid[1]) begin
                if (n < 4) begin got[n] = resp_rdata[1]; at[n] = c; end
                n++;
            end
            req_valid[1] = (i < 4);
            req_addr[1] = 32'h30 + 32'(4*i);
            acc = req_valid[1] && req_ready[1];
            @(posedge clk);
            if (acc) i++;
        end
        #1 req_valid[1] = 1'b0;
        tests++;
        if (n != 4) begin fails++; $display("FAIL b2b_count: got %0d, expected 4", n); end
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (got[j] !== 32'h0BAD0000 + 32'(j)) begin
                fails++; $display("FAIL b2b_data%0d: got %h, expected %h", j, got[j], 32'h0BAD0000 + 32'(j));
            end
        end
        for (int j = 1; j < 4; j++) begin
            tests++;
            if (at[j] - at[j-1] != 4) begin
                fails++; $display("FAIL b2b_spacing%0d: got %0d, expected 4", j, at[j] - at[j-1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_faults();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
